// File: rtl/tx_pad_fcs.sv
// tx_pad_fcs: transmit framing stage. Pads frames with zero bytes up to
// MIN_FRAME, appends the IEEE 802.3 CRC-32 FCS (LSB first), truncates frames
// at MAX_FRAME and discards the remainder of an oversize frame.
module tx_pad_fcs #(
  parameter int MIN_FRAME = 60,
  parameter int MAX_FRAME = 1514
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_done,
  output logic       oversize
);

  typedef enum logic [2:0] {IDLE, DATA, PAD, FCS, DROP} state_t;

  localparam logic [10:0] MIN_L = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_L = 11'(MAX_FRAME);

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [10:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        ovr_q, ovr_d;      // current frame was truncated: drop its tail after FCS
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        rst_done_q;        // keeps s_ready low while reset is applied

  logic        load;
  logic        acc;
  logic [10:0] cnt_inc;
  logic [31:0] fcs;

  assign cnt_inc = cnt_q + 11'd1;
  assign fcs     = ~crc_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      crc_q      <= 32'hFFFFFFFF;
      cnt_q      <= 11'd0;
      idx_q      <= 2'd0;
      ovr_q      <= 1'b0;
      m_data_q   <= 8'h00;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ovr_q      <= ovr_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      rst_done_q <= 1'b1;
    end
  end

  // Next state plus output-register, CRC and count updates.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ovr_d     = ovr_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q && !m_ready;
    case (state_q)
      IDLE, DATA: begin
        if (acc) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          crc_d     = crc8(crc_q, s_data);
          cnt_d     = cnt_inc;
          state_d   = DATA;
          if (s_last || cnt_inc == MAX_L) begin
            ovr_d   = !s_last;
            state_d = (cnt_inc < MIN_L) ? PAD : FCS;
          end
        end
      end
      PAD: begin
        if (load) begin
          m_data_d  = 8'h00;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          crc_d     = crc8(crc_q, 8'h00);
          cnt_d     = cnt_inc;
          if (cnt_inc == MIN_L) state_d = FCS;
        end
      end
      FCS: begin
        if (load) begin
          // Last FCS byte already in the register and draining now: frame done.
          if (m_valid_q && m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = ovr_q ? DROP : IDLE;
            crc_d     = 32'hFFFFFFFF;
            cnt_d     = 11'd0;
            idx_d     = 2'd0;
            ovr_d     = 1'b0;
          end else begin
            m_data_d  = fcs[{idx_q, 3'b000} +: 8];
            m_valid_d = 1'b1;
            m_last_d  = (idx_q == 2'd3);
            idx_d     = idx_q + 2'd1;
          end
        end
      end
      DROP: begin
        if (acc && s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs and event pulses.
  always_comb begin
    load       = !m_valid_q || m_ready;
    s_ready    = rst_done_q &&
                 ((((state_q == IDLE) || (state_q == DATA)) && load) || (state_q == DROP));
    acc        = s_valid && s_ready;
    frame_done = (state_q == FCS) && m_valid_q && m_last_q && m_ready;
    oversize   = acc && ((state_q == IDLE) || (state_q == DATA)) &&
                 (cnt_inc == MAX_L) && !s_last;
  end

endmodule

// File: doc/tx_pad_fcs.md
# tx_pad_fcs

Transmit-path framing stage between the MAC frame source and the MII/PHY byte interface. Accepts a frame as a byte stream with valid/ready handshake and pads it with zero bytes up to the minimum Ethernet length. Computes IEEE 802.3 CRC-32 over all data and pad bytes and appends the 4-byte FCS. Emits the result on a registered valid/ready output stream.

## Interface
- MIN_FRAME, 60: minimum frame length in bytes, excluding FCS; legal range 1..2047
- MAX_FRAME, 1514: maximum accepted length in bytes, excluding FCS; MAX_FRAME >= MIN_FRAME, <= 2047
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  8  input frame byte
- s_valid  in  1  s_data valid
- s_last  in  1  marks final byte of input frame
- s_ready  out  1  block accepts s_data this cycle
- m_data  out  8  output byte (data, pad or FCS)
- m_valid  out  1  m_data valid
- m_last  out  1  marks final FCS byte
- m_ready  in  1  downstream accepts m_data
- frame_done  out  1  one-cycle pulse on handshake of the final FCS byte
- oversize  out  1  one-cycle pulse when a frame is truncated at MAX_FRAME

## Operation
- States: IDLE, DATA, PAD, FCS, DROP.
- The output register (m_data/m_valid/m_last) loads when empty or being drained (!m_valid || m_ready). Contents hold while m_valid && !m_ready.
- s_ready = (IDLE or DATA) && (!m_valid || m_ready), or 1 in DROP.
- Input handshake (s_valid && s_ready) in IDLE/DATA: byte loaded to output register, CRC updated, 11-bit byte count incremented. IDLE moves to DATA on the first byte.
- On s_last, or when count reaches MAX_FRAME:
  - If count < MIN_FRAME, go to PAD.
  - Otherwise go to FCS.
- PAD: emits 0x00 bytes, each updating CRC and count, until count == MIN_FRAME, then goes to FCS.
- CRC definition: reflected, polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wise LSB-first update.
- FCS = ~crc, sent in 4 bytes, least-significant byte first. The 2-bit index counts 0..3. m_last = 1 on index 3.
- Final FCS handshake: frame_done pulses and the state returns to IDLE. CRC reloads 0xFFFFFFFF and count clears.
- Oversize: the MAX_FRAME-th byte is accepted without s_last.
  - oversize pulses on that accept.
  - The frame proceeds to FCS; the emitted frame is MAX_FRAME bytes plus FCS.
  - The next state after FCS is DROP instead of IDLE.
  - In DROP, input bytes are discarded (no output, no CRC update) up to and including s_last, then the state goes to IDLE.
  - If s_last arrives on the MAX_FRAME-th byte itself, this is not oversize: no pulse, no DROP.
- s_valid without s_ready is ignored. The source holds s_data.

## Timing
- Reset values: s_ready 0 during reset and 1 in IDLE after reset; m_valid 0, m_data 0x00, m_last 0, frame_done 0, oversize 0. State is IDLE, crc 0xFFFFFFFF, count 0.
- Latency: a byte accepted in cycle N appears on m_data in cycle N+1.
- With m_ready held high, there are no bubbles from first data byte to last FCS byte. Total output = max(len, MIN_FRAME) + 4 bytes, capped at MAX_FRAME + 4.
- s_ready is 0 throughout PAD and FCS. The first byte of the next frame is accepted no earlier than the cycle after the final FCS handshake.
- m_ready low stalls every state. Outputs stay stable and CRC/count do not advance.
- Asynchronous reset mid-frame aborts immediately to the reset values. No partial FCS is emitted.

## Test plan
- MIN_FRAME=1: input "123456789" (0x31..0x39), s_last on 0x39, m_ready=1 -> 9 data bytes then 0x26 0x39 0xF4 0xCB with m_last on 0xCB; frame_done pulses once.
- Defaults: 1-byte frame 0x31 -> 0x31, 59 bytes 0x00, 4 FCS bytes. FCS matches the reference model over those 60 bytes. 64 output beats total.
- Defaults: 100-byte frame of incrementing values -> no padding, 104 beats. FCS matches the model. oversize stays 0.
- MAX_FRAME=64, MIN_FRAME=60: 70-byte input -> oversize pulse on the 64th accept. 68 output beats. The remaining 6 bytes are accepted with no output. A following 60-byte frame is output correctly.
- Random m_ready deassertion (about 50%) on the 9-byte MIN_FRAME=1 case -> identical byte sequence. m_data held stable whenever m_valid && !m_ready.
- rst_n low in the middle of the PAD phase -> m_valid goes to 0 immediately. A new 9-byte frame after reset yields FCS 0xCBF43926 (MIN_FRAME=1).
